// File: rtl/attack_board_ctrl.sv
// ---------------------------------------------------------------------------
// attack_board_ctrl
//
// Runs one player's attack turn on an NxN Battleship board and feeds the VGA
// path. A cursor is moved with debounced button pulses. A shot is fired at
// the cursor and resolved against the opponent's ship map. Hits and misses
// are recorded, and a sticky win flag is raised once every ship cell has
// been hit.
//
// Turn flow: IDLE -> AIM -> FIRE -> RESULT -> IDLE (or WIN).
//   AIM    : cursor moves and fire requests. A per-turn timer forfeits the
//            turn after TIMEOUT_CYCLES cycles spent in AIM.
//   FIRE   : one cycle; samples enemy_ships at the latched target and
//            records the outcome.
//   RESULT : one cycle; turn_done is high, with shot_hit / timed_out valid.
//   WIN    : terminal until reset; display_win stays high.
//
// Timing: a fire pulse sampled at clock edge t is recorded in the FIRE state.
// The shot_map update and turn_done both become visible after edge t+1,
// which is the cycle labelled t+2.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   turn_start          1-cycle pulse, starts a turn (only honoured in IDLE)
//   btn_up/down/left/right
//                       1-cycle pulses, move the cursor with wrap-around
//   btn_fire            1-cycle pulse, shoot at the cursor cell
//   enemy_ships[r][c]   opponent ships; a non-zero cell holds a ship
//   cursor_map[r][c]    2'b01 at the cursor while aiming, 2'b00 elsewhere
//   shot_map[r][c]      00 untouched, 01 miss, 10 hit
//   hit_count           hits recorded so far (saturates at SHIP_CELLS)
//   turn_done           1-cycle pulse at the end of every turn
//   shot_hit            valid with turn_done: the shot hit a ship
//   timed_out           valid with turn_done: the turn was forfeited
//   display_win         sticky: all ship cells have been hit
// ---------------------------------------------------------------------------
module attack_board_ctrl #(
    parameter int N              = 5,
    parameter int SHIP_CELLS     = 6,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            turn_start,
    input  logic                            btn_up,
    input  logic                            btn_down,
    input  logic                            btn_left,
    input  logic                            btn_right,
    input  logic                            btn_fire,
    input  logic [1:0]                      enemy_ships [N][N],
    output logic [1:0]                      cursor_map  [N][N],
    output logic [1:0]                      shot_map    [N][N],
    output logic [$clog2(SHIP_CELLS+1)-1:0] hit_count,
    output logic                            turn_done,
    output logic                            shot_hit,
    output logic                            timed_out,
    output logic                            display_win
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(SHIP_CELLS + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [HW-1:0] HIT_GOAL   = HW'(SHIP_CELLS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AIM,
        S_FIRE,
        S_RESULT,
        S_WIN
    } state_t;

    // Registered state
    state_t          state_q,       state_d;
    logic [IW-1:0]   row_q,         row_d;
    logic [IW-1:0]   col_q,         col_d;
    logic [IW-1:0]   tgt_row_q,     tgt_row_d;
    logic [IW-1:0]   tgt_col_q,     tgt_col_d;
    logic [TW-1:0]   timer_q,       timer_d;
    logic [HW-1:0]   hit_count_q,   hit_count_d;
    logic            turn_done_q,   turn_done_d;
    logic            shot_hit_q,    shot_hit_d;
    logic            timed_out_q,   timed_out_d;
    logic            display_win_q, display_win_d;
    logic [1:0]      cursor_map_q [N][N];
    logic [1:0]      cursor_map_d [N][N];
    logic [1:0]      shot_map_q   [N][N];
    logic [1:0]      shot_map_d   [N][N];

    // Combinational helpers
    logic            fire_ok;
    logic            ship_hit;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        tgt_row_d     = tgt_row_q;
        tgt_col_d     = tgt_col_q;
        timer_d       = timer_q;
        hit_count_d   = hit_count_q;
        display_win_d = display_win_q;
        shot_map_d    = shot_map_q;
        // Turn-status outputs are single-cycle pulses.
        turn_done_d   = 1'b0;
        shot_hit_d    = 1'b0;
        timed_out_d   = 1'b0;
        fire_ok       = 1'b0;
        ship_hit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The cursor keeps its last position across turns.
                if (turn_start) begin
                    state_d = S_AIM;
                    timer_d = '0;
                end
            end

            S_AIM: begin
                timer_d = timer_q + TW'(1);
                fire_ok = btn_fire && (shot_map_q[row_q][col_q] == 2'b00);

                // One action per cycle. A fire pulse, even on an already-shot
                // cell, takes the cycle, and every move pulse that arrives
                // with it is dropped.
                if (btn_fire) begin
                    if (fire_ok) begin
                        state_d   = S_FIRE;
                        tgt_row_d = row_q;
                        tgt_col_d = col_q;
                    end
                end else if (btn_up) begin
                    row_d = (row_q == '0) ? LAST_IDX : row_q - IW'(1);
                end else if (btn_down) begin
                    row_d = (row_q == LAST_IDX) ? '0 : row_q + IW'(1);
                end else if (btn_left) begin
                    col_d = (col_q == '0) ? LAST_IDX : col_q - IW'(1);
                end else if (btn_right) begin
                    col_d = (col_q == LAST_IDX) ? '0 : col_q + IW'(1);
                end

                // An accepted fire in the last AIM cycle wins over the
                // timeout.
                if (!fire_ok && (timer_q == TIMER_LAST)) begin
                    state_d     = S_RESULT;
                    turn_done_d = 1'b1;
                    timed_out_d = 1'b1;
                end
            end

            S_FIRE: begin
                ship_hit = (enemy_ships[tgt_row_q][tgt_col_q] != 2'b00);
                shot_map_d[tgt_row_q][tgt_col_q] = ship_hit ? 2'b10 : 2'b01;
                if (ship_hit && (hit_count_q != HIT_GOAL)) begin
                    hit_count_d = hit_count_q + HW'(1);
                end
                state_d     = S_RESULT;
                turn_done_d = 1'b1;
                shot_hit_d  = ship_hit;
            end

            S_RESULT: begin
                if (hit_count_q == HIT_GOAL) begin
                    state_d       = S_WIN;
                    display_win_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WIN: begin
                state_d = S_WIN;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The cursor map is built from the next-state values. A move is
        // therefore visible the cycle after its button pulse, and the map
        // clears as soon as the controller leaves AIM.
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                cursor_map_d[r][c] = ((state_d == S_AIM) &&
                                      (row_d == IW'(r)) &&
                                      (col_d == IW'(c))) ? 2'b01 : 2'b00;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            tgt_row_q     <= '0;
            tgt_col_q     <= '0;
            timer_q       <= '0;
            hit_count_q   <= '0;
            turn_done_q   <= 1'b0;
            shot_hit_q    <= 1'b0;
            timed_out_q   <= 1'b0;
            display_win_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    cursor_map_q[r][c] <= 2'b00;
                    shot_map_q[r][c]   <= 2'b00;
                end
            end
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            tgt_row_q     <= tgt_row_d;
            tgt_col_q     <= tgt_col_d;
            timer_q       <= timer_d;
            hit_count_q   <= hit_count_d;
            turn_done_q   <= turn_done_d;
            shot_hit_q    <= shot_hit_d;
            timed_out_q   <= timed_out_d;
            display_win_q <= display_win_d;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    cursor_map_q[r][c] <= cursor_map_d[r][c];
                    shot_map_q[r][c]   <= shot_map_d[r][c];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cursor_map  = cursor_map_q;
    assign shot_map    = shot_map_q;
    assign hit_count   = hit_count_q;
    assign turn_done   = turn_done_q;
    assign shot_hit    = shot_hit_q;
    assign timed_out   = timed_out_q;
    assign display_win = display_win_q;

endmodule
